vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the raster timing stream that the drawing pipeline stages consume: hcount, vcount, hsync, hblnk, vsync and vblnk.
- Default timing is 800x600 @ 60 Hz (40 MHz pixel rate); all timing values are parameters.
- Sits at the head of the video pipeline. Its outputs drive the first drawing stage directly.
- Adds a pixel-enable input, so the block can run from a faster system clock, and a frame-start strobe for frame-synchronous logic.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch in pixels
- H_SYNC, 128, horizontal sync width in pixels
- H_BP, 88, horizontal back porch in pixels
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch in lines
- V_SYNC, 4, vertical sync width in lines
- V_BP, 23, vertical back porch in lines
- SYNC_POL, 1, active level of hsync_out/vsync_out (1 = active high)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel enable; the raster advances only on clk edges where pix_en=1
- hcount_out  out  11  horizontal position, 0..H_TOTAL-1
- vcount_out  out  11  vertical position, 0..V_TOTAL-1
- hsync_out  out  1  horizontal sync
- hblnk_out  out  1  horizontal blanking
- vsync_out  out  1  vertical sync
- vblnk_out  out  1  vertical blanking
- frame_start  out  1  one-clk strobe when the raster wraps to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
  - Both totals must be <= 2048; elaboration fails otherwise.
- Reset (rst_n=0, asynchronous):
  - hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, frame_start=0.
  - hsync_out and vsync_out held at inactive level (~SYNC_POL).
  - Reset takes effect immediately, mid-line or mid-frame; the raster restarts at (0,0).
- Counters, advanced on a clk edge with pix_en=1:
  - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - vcount advances only when hcount wraps: vcount = (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - On a clk edge with pix_en=0, all counters and flag outputs hold their values.
- All outputs are registered. Flags are decoded from the next counter values, so every output on a given cycle describes the same (hcount,vcount). There is no skew between outputs and zero latency relative to the counters.
  - hblnk_out = (hcount >= H_ACTIVE)
  - hsync_out = SYNC_POL when H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (default 840..967), else ~SYNC_POL
  - vblnk_out = (vcount >= V_ACTIVE)
  - vsync_out = SYNC_POL when V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (default 601..604), else ~SYNC_POL
  - vsync changes only on edges where hcount wraps to 0.
- frame_start:
  - Registered. Set to 1 on the pix_en=1 edge that moves the raster from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Cleared on the next clk edge regardless of pix_en, so it is exactly one clk wide.
  - Not asserted when leaving reset; the first frame after reset has no strobe.
- pix_en held at 1 permanently gives one pixel per clk.
- pix_en toggling gives identical sequences, stretched in time.
- Intended RTL size: about 150 lines.

Test Plan:
- Reset release, pix_en=1 -> first edge gives hcount=1, vcount=0, hblnk=0, hsync=0.
  - Edge 799 gives hcount=799, hblnk=0.
  - Edge 800 gives hcount=800, hblnk=1.
  - hsync=1 exactly for hcount 840..967.
- Run 1056 enabled edges -> hcount returns to 0 and vcount=1. vsync=1 exactly for vcount 601..604. vblnk=1 for vcount 600..627.
- Run a full frame of 1056*628=663168 edges -> raster reaches (0,0). frame_start is high for exactly one clk at that point and is never high elsewhere in the frame.
- pix_en pattern 1,0,0,1 repeated -> the output sequence matches a pix_en=1 run edge-for-edge on enabled edges. Outputs are stable on disabled edges. frame_start is still one clk wide even with pix_en=0 on the following edge.
- Assert rst_n=0 asynchronously at (500,300) mid-clock -> outputs go to 0 and syncs inactive before the next clk edge. After release the count restarts from (0,0).
- SYNC_POL=0, H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33:
  - hsync low for hcount 656..751, vsync low for vcount 490..491.
  - Line wraps after hcount 799, frame wraps after vcount 524.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing generator for the head of the video pipeline.
//            Produces pixel/line counters together with sync and blanking
//            flags, all registered and mutually aligned, plus a one-clock
//            frame-start strobe. The raster advances only on clock edges
//            where pix_en is high, so the block can run from a clock faster
//            than the pixel rate.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            pix_en       - pixel enable, raster advances when high
//            hcount_out   - horizontal position, 0..H_TOTAL-1
//            vcount_out   - vertical position, 0..V_TOTAL-1
//            hsync_out    - horizontal sync, active level SYNC_POL
//            hblnk_out    - horizontal blanking
//            vsync_out    - vertical sync, active level SYNC_POL
//            vblnk_out    - vertical blanking
//            frame_start  - one-clock strobe on the wrap to (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are 11 bits wide, so neither total may exceed 2048.
  if (H_TOTAL > 2048) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q,  hsync_d;
  logic        hblnk_q,  hblnk_d;
  logic        vsync_q,  vsync_d;
  logic        vblnk_q,  vblnk_d;
  logic        fstart_q, fstart_d;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  // Next counter values. With pix_en low everything holds.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end
    end
  end

  // Flags are decoded from the next counter values so that, once
  // registered, they describe the same raster position as the counters.
  // When pix_en is low the counters hold, so the decode reproduces the
  // current flags and they hold as well.
  always_comb begin
    hblnk_d  = (hcount_d >= H_BLNK_BEG);
    vblnk_d  = (vcount_d >= V_BLNK_BEG);
    hsync_d  = ((hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END)) ?
               SYNC_POL : ~SYNC_POL;
    vsync_d  = ((vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END)) ?
               SYNC_POL : ~SYNC_POL;
    // Strobe only on the enabled edge that wraps the whole raster; any
    // other edge clears it, so it is always exactly one clock wide.
    fstart_d = pix_en && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= ~SYNC_POL;
      hblnk_q  <= 1'b0;
      vsync_q  <= ~SYNC_POL;
      vblnk_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
      fstart_q <= fstart_d;
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign hsync_out   = hsync_q;
  assign hblnk_out   = hblnk_q;
  assign vsync_out   = vsync_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = fstart_q;

endmodule
`default_nettype wire
